// File: rtl/pixel_frame_tx_if.sv
// Handshake bundle between the frame transmitter, its frame-buffer loader and the downstream CNN.
// master = transmitter side, slave = host/CNN side.
interface pixel_frame_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 wr_en;
  logic [9:0]           wr_addr;
  logic [DATA_BITS-1:0] wr_data;
  logic                 start;
  logic                 busy;
  logic                 pix_val;
  logic [DATA_BITS-1:0] pix_data;
  logic                 res_val;
  logic [3:0]           res_class;
  logic                 done;
  logic [3:0]           class_out;
  logic                 timeout;

  modport master (
    input  wr_en, wr_addr, wr_data, start, res_val, res_class,
    output busy, pix_val, pix_data, done, class_out, timeout
  );

  modport slave (
    output wr_en, wr_addr, wr_data, start, res_val, res_class,
    input  busy, pix_val, pix_data, done, class_out, timeout
  );
endinterface

// File: rtl/pixel_frame_tx.sv
// Buffers one image and streams it pixel by pixel into a CNN, then captures the class decision.
// Optional WAIT-state watchdog is enabled by defining PIXEL_FRAME_TX_TIMEOUT_EN.
module pixel_frame_tx #(
  parameter int IMG_PIXELS = 784,
  parameter int DATA_BITS  = 8,
  parameter int GAP        = 0
) (
  input  logic              clk,
  input  logic              rst,
  pixel_frame_tx_if.master  bus
);
  localparam int              AW       = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
  localparam int              GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [AW-1:0]   LAST_IDX = AW'(IMG_PIXELS - 1);
  localparam logic [10:0]     PIX_LIM  = 11'(IMG_PIXELS);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] frame_mem [IMG_PIXELS];
  logic [AW-1:0]        pix_idx;
  logic [GW-1:0]        gap_cnt;
  logic                 issued_all;
  logic                 rd_vld;
  logic                 rd_last;
  logic [DATA_BITS-1:0] rd_q;
  logic                 res_seen;
  logic                 busy_q;
  logic                 pix_val_q;
  logic [DATA_BITS-1:0] pix_data_q;
  logic                 done_q;
  logic [3:0]           class_q;
  logic                 timeout_q;
  logic                 wr_ok;
  logic                 issue;

  assign wr_ok = bus.wr_en && (state == IDLE) && ({1'b0, bus.wr_addr} < PIX_LIM);
  assign issue = (state == SEND) && !issued_all && (gap_cnt == '0);

  // NOTE: the frame buffer has no reset; its contents must survive rst and a
  // reset port would also prevent RAM inference.
  always_ff @(posedge clk) begin
    if (wr_ok) frame_mem[bus.wr_addr[AW-1:0]] <= bus.wr_data;
    if (issue) rd_q <= frame_mem[pix_idx];
  end

`ifdef PIXEL_FRAME_TX_TIMEOUT_EN
  logic [11:0] wdog;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pix_idx    <= '0;
      gap_cnt    <= '0;
      issued_all <= 1'b0;
      rd_vld     <= 1'b0;
      rd_last    <= 1'b0;
      res_seen   <= 1'b0;
      busy_q     <= 1'b0;
      pix_val_q  <= 1'b0;
      pix_data_q <= '0;
      done_q     <= 1'b0;
      class_q    <= '0;
      timeout_q  <= 1'b0;
`ifdef PIXEL_FRAME_TX_TIMEOUT_EN
      wdog       <= '0;
`endif
    end else begin
      // NOTE: done_q gets a default here so every branch below yields a single-cycle pulse.
      done_q <= 1'b0;

      // Second stage of the read pipeline: present the registered buffer word.
      pix_val_q <= rd_vld;
      if (rd_vld) pix_data_q <= rd_q;

      rd_vld  <= issue;
      rd_last <= issue && (pix_idx == LAST_IDX);
      if (issue) begin
        if (pix_idx == LAST_IDX) issued_all <= 1'b1;
        else                     pix_idx    <= pix_idx + 1'b1;
        gap_cnt <= GW'(GAP);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= SEND;
            busy_q     <= 1'b1;
            pix_idx    <= '0;
            gap_cnt    <= '0;
            issued_all <= 1'b0;
            res_seen   <= 1'b0;
`ifdef PIXEL_FRAME_TX_TIMEOUT_EN
            wdog       <= '0;
`endif
          end
        end
        SEND: begin
          // An early result is kept, but the stream always runs to the last pixel.
          if (bus.res_val) begin
            class_q   <= bus.res_class;
            timeout_q <= 1'b0;
            res_seen  <= 1'b1;
          end
          if (rd_vld && rd_last) state <= WAIT;
        end
        WAIT: begin
          if (bus.res_val || res_seen) begin
            if (bus.res_val) begin
              class_q   <= bus.res_class;
              timeout_q <= 1'b0;
            end
            state  <= DONE;
            done_q <= 1'b1;
          end
`ifdef PIXEL_FRAME_TX_TIMEOUT_EN
          else if (wdog == 12'hFFF) begin
            timeout_q <= 1'b1;
            state     <= DONE;
            done_q    <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.pix_val   = pix_val_q;
  assign bus.pix_data  = pix_data_q;
  assign bus.done      = done_q;
  assign bus.class_out = class_q;
`ifdef PIXEL_FRAME_TX_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_frame_tx.sv
// Directed bench for pixel_frame_tx: GAP=0 instance for streaming/result/reset cases,
// GAP=2 instance for pixel spacing; watchdog cases follow PIXEL_FRAME_TX_TIMEOUT_EN.
module tb_pixel_frame_tx;
  localparam int NPIX = 784;

  logic clk;
  logic rst;
  int   total_cnt;
  int   pass_cnt;

  pixel_frame_tx_if #(.DATA_BITS(8)) a_if ();
  pixel_frame_tx_if #(.DATA_BITS(8)) b_if ();

  pixel_frame_tx #(.IMG_PIXELS(NPIX), .DATA_BITS(8), .GAP(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  pixel_frame_tx #(.IMG_PIXELS(NPIX), .DATA_BITS(8), .GAP(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         res_delay;   // cycles after last pixel; -1 = during SEND
    logic [3:0] cls;
    bit         inject;      // re-pulse start and stray writes mid-stream
    logic [3:0] exp_class;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Starts a frame on dut0 and checks the whole stream; returns on the last-pixel cycle.
  task automatic send_frame(input bit res_in_send, input logic [3:0] cls, input bit inject);
    int errs;
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
    check("start_busy", a_if.busy, 1);
    check("start_nopix", a_if.pix_val, 0);
    tick();
    check("first_lat", a_if.pix_val, 0);
    tick();
    errs = 0;
    for (int k = 0; k < NPIX; k++) begin
      if (k > 0) tick();
      if (a_if.pix_val !== 1'b1 || a_if.pix_data !== 8'(k % 256) || a_if.busy !== 1'b1) errs++;
      if (inject) begin
        if (k == 100) begin
          a_if.start = 1'b1; a_if.wr_en = 1'b1; a_if.wr_addr = 10'd5; a_if.wr_data = 8'hEE;
        end else if (k == 101) begin
          a_if.start = 1'b0; a_if.wr_addr = 10'd800; a_if.wr_data = 8'hAA;
        end else if (k == 102) begin
          a_if.wr_en = 1'b0;
        end
      end
      if (res_in_send) begin
        if (k == 400) begin a_if.res_val = 1'b1; a_if.res_class = cls; end
        else if (k == 401) a_if.res_val = 1'b0;
      end
    end
    check("stream", errs, 0);
  endtask

  // From the last-pixel cycle: optionally deliver a result d cycles later, then check done/return.
  task automatic finish_frame(input int d, input logic [3:0] cls, input logic [3:0] exp_cls);
    int errs;
    if (d < 0) begin
      tick();
    end else begin
      errs = 0;
      for (int j = 0; j < d; j++) begin
        tick();
        if (a_if.pix_val !== 1'b0 || a_if.done !== 1'b0 || a_if.busy !== 1'b1) errs++;
      end
      if (d > 0) check("wait_quiet", errs, 0);
      a_if.res_val   = 1'b1;
      a_if.res_class = cls;
      tick();
      a_if.res_val   = 1'b0;
    end
    check("done_pulse", a_if.done, 1);
    check("class_out", a_if.class_out, exp_cls);
    check("timeout_clr", a_if.timeout, 0);
    a_if.start = 1'b1;   // coincides with DONE, must be ignored
    tick();
    a_if.start = 1'b0;
    check("done_one_cycle", a_if.done, 0);
    check("idle_busy", a_if.busy, 0);
    tick();
    check("start_in_done_ignored", a_if.busy, 0);
  endtask

  initial begin
    int errs;
    int cnt;
    total_cnt = 0;
    pass_cnt  = 0;
    rst = 1'b1;
    a_if.wr_en = 1'b0; a_if.wr_addr = '0; a_if.wr_data = '0; a_if.start = 1'b0;
    a_if.res_val = 1'b0; a_if.res_class = '0;
    b_if.wr_en = 1'b0; b_if.wr_addr = '0; b_if.wr_data = '0; b_if.start = 1'b0;
    b_if.res_val = 1'b0; b_if.res_class = '0;

    vecs[0] = '{res_delay: 10, cls: 4'd7,  inject: 1'b1, exp_class: 4'd7};
    vecs[1] = '{res_delay: 0,  cls: 4'd3,  inject: 1'b0, exp_class: 4'd3};
    vecs[2] = '{res_delay: -1, cls: 4'd9,  inject: 1'b0, exp_class: 4'd9};
    vecs[3] = '{res_delay: 1,  cls: 4'd15, inject: 1'b0, exp_class: 4'd15};

    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", a_if.busy, 0);
    check("rst_pix_val", a_if.pix_val, 0);
    check("rst_pix_data", a_if.pix_data, 0);
    check("rst_done", a_if.done, 0);
    check("rst_class_out", a_if.class_out, 0);
    check("rst_timeout", a_if.timeout, 0);

    // Load both frame buffers with i mod 256, plus one out-of-range write.
    for (int i = 0; i <= NPIX; i++) begin
      a_if.wr_en = 1'b1; b_if.wr_en = 1'b1;
      a_if.wr_addr = (i == NPIX) ? 10'd800 : 10'(i);
      b_if.wr_addr = a_if.wr_addr;
      a_if.wr_data = (i == NPIX) ? 8'h55 : 8'(i % 256);
      b_if.wr_data = a_if.wr_data;
      tick();
    end
    a_if.wr_en = 1'b0; b_if.wr_en = 1'b0;

    // Result strobe in IDLE must not be captured.
    a_if.res_val = 1'b1; a_if.res_class = 4'd2;
    tick();
    a_if.res_val = 1'b0;
    check("idle_res_done", a_if.done, 0);
    check("idle_res_class", a_if.class_out, 0);

    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v].res_delay < 0, vecs[v].cls, vecs[v].inject);
      finish_frame(vecs[v].res_delay, vecs[v].cls, vecs[v].exp_class);
    end

    a_if.res_val = 1'b1; a_if.res_class = 4'd1;
    tick();
    a_if.res_val = 1'b0;
    check("idle_res_class2", a_if.class_out, 15);

    // GAP=2 instance: one valid pixel every third cycle.
    b_if.start = 1'b1;
    tick();
    b_if.start = 1'b0;
    tick();
    check("gap_first_lat", b_if.pix_val, 0);
    tick();
    errs = 0;
    for (int c = 0; c < NPIX + 2 * (NPIX - 1); c++) begin
      if (c > 0) tick();
      if (b_if.pix_val !== ((c % 3) == 0)) errs++;
      if ((c % 3) == 0 && b_if.pix_data !== 8'((c / 3) % 256)) errs++;
      if (b_if.busy !== 1'b1) errs++;
    end
    check("gap_stream", errs, 0);
    errs = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      if (b_if.pix_val !== 1'b0) errs++;
    end
    check("gap_no_extra", errs, 0);
    b_if.res_val = 1'b1; b_if.res_class = 4'd5;
    tick();
    b_if.res_val = 1'b0;
    check("gap_done", b_if.done, 1);
    check("gap_class", b_if.class_out, 5);
    repeat (2) tick();

    // Reset at pixel 300, then replay from pixel 0 with buffer intact.
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
    repeat (2 + 300) tick();
    check("pix300_data", a_if.pix_data, 300 % 256);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_pix_val", a_if.pix_val, 0);
    check("midrst_busy", a_if.busy, 0);
    check("midrst_class", a_if.class_out, 0);
    tick();
    check("midrst_stay_idle", a_if.pix_val, 0);
    send_frame(1'b0, 4'd0, 1'b0);
    finish_frame(2, 4'd4, 4'd4);

`ifdef PIXEL_FRAME_TX_TIMEOUT_EN
    send_frame(1'b0, 4'd0, 1'b0);
    cnt = 0;
    while (a_if.done !== 1'b1 && cnt < 5000) begin
      tick();
      cnt++;
    end
    check("wdog_cycles", cnt, 4096);
    check("wdog_timeout", a_if.timeout, 1);
    check("wdog_class_kept", a_if.class_out, 4);
    tick();
    check("wdog_idle", a_if.busy, 0);
    check("wdog_sticky", a_if.timeout, 1);
    send_frame(1'b0, 4'd0, 1'b0);
    finish_frame(3, 4'd6, 4'd6);
`else
    send_frame(1'b0, 4'd0, 1'b0);
    errs = 0;
    for (int j = 0; j < 4200; j++) begin
      tick();
      if (a_if.done !== 1'b0 || a_if.timeout !== 1'b0 || a_if.busy !== 1'b1) errs++;
    end
    check("no_wdog_wait", errs, 0);
    check("no_wdog_class", a_if.class_out, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wait_rst_busy", a_if.busy, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
